fd_window_gen: RTL

FD_WINDOW_GEN -- requirements
Module: fd_window_gen

---
 rtl/fd_pkg.sv | 56 +++++
 rtl/fd_line_buffer.sv | 32 +++
 rtl/fd_window_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fd_pkg.sv
// fd_pkg: shared constants for the FAST detector front end.
//   PIX_W    - grey pixel width
//   CIRCLE_N - number of Bresenham circle taps
//   RADIUS   - circle radius; the centre sits RADIUS columns/rows inside the window
//   WIN      - square window size (2*RADIUS+1)
//   circle_dx/circle_dy - tap offsets from the centre, y growing downward, tap 0 = position 1
package fd_pkg;

   localparam int PIX_W    = 8;
   localparam int CIRCLE_N = 16;
   localparam int RADIUS   = 3;
   localparam int WIN      = 7;

   function automatic int circle_dx(input int idx);
      case (idx)
         0:  return 0;
         1:  return 1;
         2:  return 2;
         3:  return 3;
         4:  return 3;
         5:  return 3;
         6:  return 2;
         7:  return 1;
         8:  return 0;
         9:  return -1;
         10: return -2;
         11: return -3;
         12: return -3;
         13: return -3;
         14: return -2;
         default: return -1;
      endcase
   endfunction

   function automatic int circle_dy(input int idx);
      case (idx)
         0:  return -3;
         1:  return -3;
         2:  return -2;
         3:  return -1;
         4:  return 0;
         5:  return 1;
         6:  return 2;
         7:  return 3;
         8:  return 3;
         9:  return 3;
         10: return 2;
         11: return 1;
         12: return 0;
         13: return -1;
         14: return -2;
         default: return -3;
      endcase
   endfunction

endpackage

// File: rtl/fd_line_buffer.sv
// fd_line_buffer: one image row of pixel storage.
//   i_clk   - clock
//   i_en    - write enable (pixel accepted)
//   i_addr  - column address, shared by read and write
//   i_wdata - pixel written at i_addr
//   o_rdata - asynchronous read of i_addr; returns the value before this cycle's write
module fd_line_buffer
   import fd_pkg::*;
#(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned AW    = 10
) (
   input  logic             i_clk,
   input  logic             i_en,
   input  logic [AW-1:0]    i_addr,
   input  logic [PIX_W-1:0] i_wdata,
   output logic [PIX_W-1:0] o_rdata
);

   logic [PIX_W-1:0] r_mem [DEPTH];

   // Read is combinational so the old column value is available to the next
   // line buffer in the same cycle it gets overwritten here.
   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge i_clk) begin
      if (i_en) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

endmodule

// File: rtl/fd_window_gen.sv
// fd_window_gen: raster pixel stream in, 7x7 window centre plus 16 circle taps out.
//   clk, reset            - clock, synchronous active-high reset
//   inPixel/inValid/inSof - input pixel, valid, start-of-frame qualifier
//   inReady               - input accepted when inValid && inReady
//   refPixel              - window centre pixel
//   adjPixel              - circle taps, position 1 in the top byte
//   outX/outY             - centre coordinates
//   outEof                - set on the last centre of a frame
//   outValid/outReady     - output handshake
module fd_window_gen
   import fd_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [PIX_W-1:0]          inPixel,
   input  logic                      inValid,
   input  logic                      inSof,
   output logic                      inReady,
   output logic [PIX_W-1:0]          refPixel,
   output logic [CIRCLE_N*PIX_W-1:0] adjPixel,
   output logic [9:0]                outX,
   output logic [8:0]                outY,
   output logic                      outEof,
   output logic                      outValid,
   input  logic                      outReady
);

   localparam int LB_N = WIN - 1;
   localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
   localparam logic [8:0] ROW_LAST = 9'(IMG_H - 1);
   localparam logic [9:0] COL_MIN  = 10'(WIN - 1);
   localparam logic [8:0] ROW_MIN  = 9'(WIN - 1);

   logic [9:0]                r_col_cnt;
   logic [8:0]                r_row_cnt;
   logic [9:0]                w_col;
   logic [8:0]                w_row;
   logic                      w_accept;
   logic                      w_emit;
   logic                      w_eof;

   logic [PIX_W-1:0]          r_win      [WIN][WIN];
   logic [PIX_W-1:0]          w_win_next [WIN][WIN];
   logic [PIX_W-1:0]          w_colv     [WIN];
   logic [PIX_W-1:0]          w_lb_rd    [LB_N];
   logic [CIRCLE_N*PIX_W-1:0] w_adj;

   logic                      r_out_valid;
   logic                      r_out_eof;
   logic [PIX_W-1:0]          r_ref;
   logic [CIRCLE_N*PIX_W-1:0] r_adj;
   logic [9:0]                r_out_x;
   logic [8:0]                r_out_y;

   assign inReady  = !r_out_valid || outReady;
   assign w_accept = inValid && inReady;

   // A start-of-frame pixel is indexed as (0,0) regardless of the counters.
   assign w_col = inSof ? 10'd0 : r_col_cnt;
   assign w_row = inSof ? 9'd0 : r_row_cnt;

   // Only windows lying fully inside the current frame become centres; this also
   // masks stale columns after a row wrap and stale rows after a resync.
   assign w_emit = (w_col >= COL_MIN) && (w_row >= ROW_MIN);
   assign w_eof  = (w_col == COL_LAST) && (w_row == ROW_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_col_cnt <= '0;
         r_row_cnt <= '0;
      end else if (w_accept) begin
         if (w_col == COL_LAST) begin
            r_col_cnt <= '0;
            r_row_cnt <= (w_row == ROW_LAST) ? 9'd0 : w_row + 9'd1;
         end else begin
            r_col_cnt <= w_col + 10'd1;
            r_row_cnt <= w_row;
         end
      end
   end

   // Line buffer k holds row y-1-k; each feeds the next so a column cascades up.
   for (genvar gk = 0; gk < LB_N; gk++) begin : g_lb
      logic [PIX_W-1:0] w_wdata;
      if (gk == 0) begin : g_first
         assign w_wdata = inPixel;
      end else begin : g_chain
         assign w_wdata = w_lb_rd[gk-1];
      end
      fd_line_buffer #(
         .DEPTH (IMG_W),
         .AW    (10)
      ) u_lb (
         .i_clk   (clk),
         .i_en    (w_accept),
         .i_addr  (w_col),
         .i_wdata (w_wdata),
         .o_rdata (w_lb_rd[gk])
      );
   end

   // Incoming column, top row (oldest) first.
   for (genvar gr = 0; gr < WIN; gr++) begin : g_colv
      if (gr == WIN - 1) begin : g_new
         assign w_colv[gr] = inPixel;
      end else begin : g_old
         assign w_colv[gr] = w_lb_rd[WIN-2-gr];
      end
   end

   // Window after this cycle's shift; rightmost column is the newest.
   for (genvar gr = 0; gr < WIN; gr++) begin : g_row
      for (genvar gc = 0; gc < WIN; gc++) begin : g_col
         if (gc == WIN - 1) begin : g_in
            assign w_win_next[gr][gc] = w_colv[gr];
         end else begin : g_sh
            assign w_win_next[gr][gc] = r_win[gr][gc+1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_win <= w_win_next;
      end
   end

   for (genvar gi = 0; gi < CIRCLE_N; gi++) begin : g_adj
      localparam int DX = circle_dx(gi);
      localparam int DY = circle_dy(gi);
      assign w_adj[(CIRCLE_N-gi)*PIX_W-1 -: PIX_W] = w_win_next[RADIUS+DY][RADIUS+DX];
   end

   // Output register: loads on an emitting acceptance (which implies the previous
   // output is gone or leaving), otherwise clears once the consumer takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_eof   <= 1'b0;
         r_ref       <= '0;
         r_adj       <= '0;
         r_out_x     <= '0;
         r_out_y     <= '0;
      end else if (w_accept && w_emit) begin
         r_out_valid <= 1'b1;
         r_out_eof   <= w_eof;
         r_ref       <= w_win_next[RADIUS][RADIUS];
         r_adj       <= w_adj;
         r_out_x     <= w_col - 10'(RADIUS);
         r_out_y     <= w_row - 9'(RADIUS);
      end else if (outReady) begin
         r_out_valid <= 1'b0;
      end
   end

   assign outValid = r_out_valid;
   assign outEof   = r_out_eof;
   assign refPixel = r_ref;
   assign adjPixel = r_adj;
   assign outX     = r_out_x;
   assign outY     = r_out_y;

endmodule
